// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner IDs and
// the latency counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // The latency counter runs 0..lat-1, so it needs at least one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// With MEM_ARB_STARVE_GUARD_EN defined, IF overrides LS priority once starved.
module mem_arb_pick
    import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
)
`endif
(
    input  logic   if_req,
    input  logic   ls_req,
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic   grant,
    output owner_e owner
);

    always_comb begin
        grant = if_req | ls_req;
        owner = OWN_IF;
        if (ls_req) begin
            owner = OWN_LS;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (ls_req && if_req && (starve_cnt == CNT_W'(STARVE_MAX))) begin
            owner = OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
)
(
    input  logic              CLK,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               LAT_W    = lat_cnt_w(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              mem_ena_q, mem_ena_d;
    logic              mem_wena_q, mem_wena_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              pick_grant;
    owner_e            pick_owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    mem_arb_pick
`ifdef MEM_ARB_STARVE_GUARD_EN
    #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (STARVE_W)
    )
`endif
    u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
`ifdef MEM_ARB_STARVE_GUARD_EN
        .starve_cnt (starve_q),
`endif
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        mem_ena_d   = mem_ena_q;
        mem_wena_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    state_d   = ST_ACCESS;
                    owner_d   = pick_owner;
                    lat_cnt_d = '0;
                    mem_ena_d = 1'b1;
                    if (pick_owner == OWN_LS) begin
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        we_d        = ls_we;
                        mem_wena_d  = ls_we;
                    end else begin
                        mem_addr_d = if_addr;
                        we_d       = 1'b0;
                    end
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (pick_owner == OWN_IF) begin
                        starve_d = '0;
                    end else if (if_req) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
`endif
                end
            end
            ST_ACCESS: begin
                // Read data is only sampled on the final cycle the port is held.
                if (lat_cnt_q == LAT_LAST) begin
                    state_d   = ST_DONE;
                    mem_ena_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d = 1'b1;
                        if (!we_q) begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        ls_ack_d = 1'b1;
                        if (!we_q) begin
                            ls_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_ena_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            mem_ena_q   <= 1'b0;
            mem_wena_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_ena_q   <= mem_ena_d;
            mem_wena_q  <= mem_wena_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_ena   = mem_ena_q;
    assign mem_wena  = mem_wena_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
